// File: rtl/scratchpad_mls_responder_if.sv
// Request, scratchpad and matrix-regfile signal bundle for the matrix load/store responder.
// The responder uses the slave modport; the requester/memory/regfile side uses master.
interface scratchpad_mls_responder_if #(
  parameter int ROWS  = 4,
  parameter int ROW_W = 64
);
  localparam int ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  // request channel
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           ls_in;
  logic [3:0]           rd_in;
  logic [10:0]          imm_in;
  logic [31:0]          address_in;
  logic [31:0]          stride_in;

  // scratchpad channel
  logic                 mem_req;
  logic                 mem_wen;
  logic [31:0]          mem_addr;
  logic [ROW_W-1:0]     mem_wdata;
  logic                 mem_ack;
  logic [ROW_W-1:0]     mem_rdata;

  // matrix register file channel
  logic                 mrf_wen;
  logic                 mrf_ren;
  logic [3:0]           mrf_idx;
  logic [ROW_IDX_W-1:0] mrf_row;
  logic [ROW_W-1:0]     mrf_wdata;
  logic [ROW_W-1:0]     mrf_rdata;

  // completion
  logic                 resp_done;
  logic [3:0]           resp_rd;
  logic                 resp_err;

  modport slave (
    input  req_valid, ls_in, rd_in, imm_in, address_in, stride_in,
    output req_ready,
    output mem_req, mem_wen, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output mrf_wen, mrf_ren, mrf_idx, mrf_row, mrf_wdata,
    input  mrf_rdata,
    output resp_done, resp_rd, resp_err
  );

  modport master (
    output req_valid, ls_in, rd_in, imm_in, address_in, stride_in,
    input  req_ready,
    input  mem_req, mem_wen, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  mrf_wen, mrf_ren, mrf_idx, mrf_row, mrf_wdata,
    output mrf_rdata,
    input  resp_done, resp_rd, resp_err
  );
endinterface

// File: rtl/scratchpad_mls_responder.sv
// Matrix load/store responder: moves ROWS rows between the matrix register file and the
// scratchpad, one row per scratchpad handshake, with strided addressing.
module scratchpad_mls_responder #(
  parameter int ROWS  = 4,
  parameter int ROW_W = 64
) (
  input  logic                          CLK,
  input  logic                          nRST,
  scratchpad_mls_responder_if.slave     bus
);
  localparam int ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]           state_reg,  state_next;
  logic [ROW_IDX_W-1:0] row_reg,    row_next;
  logic [31:0]          addr_reg,   addr_next;
  logic [31:0]          stride_reg, stride_next;
  logic [3:0]           rd_reg,     rd_next;
  logic                 store_reg,  store_next;
  logic                 err_reg,    err_next;

  logic        in_idle;
  logic        in_access;
  logic        in_done;
  logic        accept;
  logic        ls_legal;
  logic [31:0] imm_ext;

  assign in_idle   = (state_reg == ST_IDLE);
  assign in_access = (state_reg == ST_ACCESS);
  assign in_done   = (state_reg == ST_DONE);
  assign accept    = bus.req_valid && in_idle;
  assign ls_legal  = (bus.ls_in == 2'b10) || (bus.ls_in == 2'b01);
  assign imm_ext   = {{21{bus.imm_in[10]}}, bus.imm_in};

  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    addr_next   = addr_reg;
    stride_next = stride_reg;
    rd_next     = rd_reg;
    store_next  = store_reg;
    err_next    = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          rd_next     = bus.rd_in;
          stride_next = bus.stride_in;
          addr_next   = bus.address_in + imm_ext;
          row_next    = '0;
          store_next  = bus.ls_in[0];
          err_next    = !ls_legal;
          state_next  = ls_legal ? ST_ACCESS : ST_DONE;
        end
      end
      ST_ACCESS: begin
        // addr_reg always holds the address of the current row, so it advances by
        // one stride per completed row instead of multiplying row by stride.
        if (bus.mem_ack) begin
          if (row_reg == LAST_ROW) begin
            state_next = ST_DONE;
          end else begin
            row_next  = row_reg + 1'b1;
            addr_next = addr_reg + stride_reg;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg  <= ST_IDLE;
      row_reg    <= '0;
      addr_reg   <= '0;
      stride_reg <= '0;
      rd_reg     <= '0;
      store_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      addr_reg   <= addr_next;
      stride_reg <= stride_next;
      rd_reg     <= rd_next;
      store_reg  <= store_next;
      err_reg    <= err_next;
    end
  end

  // Outputs decode straight from registered state, so an asynchronous reset
  // clears them in the same instant the state registers clear.
  assign bus.req_ready = in_idle;

  assign bus.mem_req   = in_access;
  assign bus.mem_wen   = in_access && store_reg;
  assign bus.mem_addr  = in_access ? addr_reg : 32'd0;
  assign bus.mem_wdata = (in_access && store_reg) ? bus.mrf_rdata : '0;

  assign bus.mrf_ren   = in_access && store_reg;
  assign bus.mrf_wen   = in_access && !store_reg && bus.mem_ack;
  assign bus.mrf_idx   = in_access ? rd_reg : 4'd0;
  assign bus.mrf_row   = in_access ? row_reg : '0;
  assign bus.mrf_wdata = (in_access && !store_reg && bus.mem_ack) ? bus.mem_rdata : '0;

  assign bus.resp_done = in_done;
  assign bus.resp_rd   = in_done ? rd_reg : 4'd0;
  assign bus.resp_err  = in_done && err_reg;

endmodule
